pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC).
- Resolves, by fixed priority: data-memory wait with timeout, multi-cycle EX busy, EX-stage jump/branch redirect, and load-use hazard.
- Emits a hold (stall) and a bubble-insert (flush) per pipeline register.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for a five-stage pipeline: data-memory wait with timeout,
// multi-cycle EX busy, EX redirect and load-use hazards, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_raddr_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_raddr_i,
  input  logic             id_rs2_re_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_reg_waddr_i,
  input  logic             ex_jump_i,
  input  logic             ex_busy_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic wait_last, mem_hold, timeout, load_use;

  always_comb begin
    wait_last = (state_q == StMemWait) && (wait_cnt_q == WaitLast);
    mem_hold  = ((state_q == StRun) && mem_req_i && !mem_ack_i) ||
                ((state_q == StMemWait) && !mem_ack_i && !wait_last);
    timeout   = wait_last && !mem_ack_i;
    load_use  = ex_is_load_i && (ex_reg_waddr_i != 5'd0) &&
                ((id_rs1_re_i && (id_rs1_raddr_i == ex_reg_waddr_i)) ||
                 (id_rs2_re_i && (id_rs2_raddr_i == ex_reg_waddr_i)));
  end

  // Next-state: mem_req_i is only looked at in StRun.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_ack_i || wait_last) begin
          state_d = StRun;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Fixed-priority stall/flush decode; everything is forced low during reset.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    bus_err_o      = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (timeout) begin
        bus_err_o      = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (ex_busy_i) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (ex_jump_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
      end else if (load_use) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (pc_stall_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl: directed scenarios plus random traffic, all checked
// against an access-age based reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 8;
  localparam int CntMax = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    rs1_addr, rs2_addr, ex_waddr;
  logic          rs1_re, rs2_re, ex_load, ex_jump, ex_busy, mem_req, mem_ack;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, ex_mem_flush, mem_wb_flush, bus_err;
  logic [CW-1:0] stall_cnt;
  logic [8:0]    out_vec;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_raddr_i (rs1_addr),
    .id_rs1_re_i    (rs1_re),
    .id_rs2_raddr_i (rs2_addr),
    .id_rs2_re_i    (rs2_re),
    .ex_is_load_i   (ex_load),
    .ex_reg_waddr_i (ex_waddr),
    .ex_jump_i      (ex_jump),
    .ex_busy_i      (ex_busy),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_stall_o  (id_ex_stall),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_stall_o (ex_mem_stall),
    .ex_mem_flush_o (ex_mem_flush),
    .mem_wb_flush_o (mem_wb_flush),
    .bus_err_o      (bus_err),
    .stall_cnt_o    (stall_cnt)
  );

  assign out_vec = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                    ex_mem_stall, ex_mem_flush, mem_wb_flush, bus_err};

  int n_checks = 0;
  int n_fail   = 0;
  // Model: acc_age < 0 means no access outstanding, otherwise stall cycles already spent on it.
  int acc_age   = -1;
  int model_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_out();
    logic hold, tmo, lu;
    if (rst) return 9'b0;
    hold = 1'b0;
    tmo  = 1'b0;
    if (acc_age < 0) hold = mem_req && !mem_ack;
    else if (!mem_ack) begin
      if (acc_age >= int'(TO)) tmo = 1'b1;
      else hold = 1'b1;
    end
    lu = ex_load && ex_waddr != 0 &&
         ((rs1_re && rs1_addr == ex_waddr) || (rs2_re && rs2_addr == ex_waddr));
    if (hold)    return 9'b1_1_0_1_0_1_0_1_0;
    if (tmo)     return 9'b0_0_0_0_0_0_0_1_1;
    if (ex_busy) return 9'b1_1_0_1_0_0_1_0_0;
    if (ex_jump) return 9'b0_0_1_0_1_0_0_0_0;
    if (lu)      return 9'b1_1_0_0_1_0_0_0_0;
    return 9'b0;
  endfunction

  // Inputs are set just after a negedge; check mid-cycle, then advance across one posedge.
  task automatic tick(input string tag);
    logic [8:0] e;
    #1;
    e = model_out();
    check_eq(tag, 32'(out_vec), 32'(e));
    check_eq({tag, "_cnt"}, 32'(stall_cnt), 32'(model_cnt));
    @(posedge clk);
    if (rst) begin
      acc_age   = -1;
      model_cnt = 0;
    end else begin
      if (e[8] && model_cnt < CntMax) model_cnt++;
      if (acc_age < 0) begin
        if (mem_req && !mem_ack) acc_age = 1;
      end else if (mem_ack || acc_age >= int'(TO)) acc_age = -1;
      else acc_age++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rs1_addr = '0; rs2_addr = '0; ex_waddr = '0;
    rs1_re = 1'b0; rs2_re = 1'b0; ex_load = 1'b0; ex_jump = 1'b0;
    ex_busy = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
  endtask

  int stalls;
  int err_at;
  int ack_pct;

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    #1 check_eq("reset_cnt", 32'(stall_cnt), 0);
    check_eq("reset_out", 32'(out_vec), 0);

    // Load-use: one bubble, then nothing.
    ex_load = 1'b1; ex_waddr = 5'd5; rs2_re = 1'b1; rs2_addr = 5'd5;
    #1 check_eq("lu_vec", 32'(out_vec), 32'(9'b1_1_0_0_1_0_0_0_0));
    tick("lu");
    idle();
    tick("lu_after");
    check_eq("lu_cnt", 32'(stall_cnt), 1);
    ex_load = 1'b1; ex_waddr = 5'd0; rs2_re = 1'b1; rs2_addr = 5'd0;
    #1 check_eq("lu_x0", 32'(out_vec), 0);
    tick("lu_x0");
    // Jump beats load-use.
    ex_waddr = 5'd5; rs2_addr = 5'd5; ex_jump = 1'b1;
    #1 check_eq("jmp_lu", 32'(out_vec), 32'(9'b0_0_1_0_1_0_0_0_0));
    tick("jmp_lu");

    // Late ack after three stalled cycles.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick("late_wait");
    mem_ack = 1'b1;
    #1 check_eq("late_ack_stall", 32'(pc_stall), 0);
    tick("late_ack");
    idle();
    tick("late_after");
    check_eq("late_cnt", 32'(stall_cnt), 3);

    // Timeout: request once, never ack.
    do_reset();
    stalls = 0;
    err_at = -1;
    mem_req = 1'b1;
    for (int i = 0; i < int'(TO) + 3; i++) begin
      #1;
      if (pc_stall) stalls++;
      if (bus_err && err_at < 0) err_at = i;
      tick("tmo");
      mem_req = 1'b0;
    end
    check_eq("tmo_stalls", 32'(stalls), 32'(TO));
    check_eq("tmo_err_cycle", 32'(err_at), 32'(TO));

    // Busy and jump during a wait are masked, then busy takes effect after ack.
    do_reset();
    mem_req = 1'b1;
    tick("mw_req");
    mem_req = 1'b0; ex_busy = 1'b1; ex_jump = 1'b1;
    #1 check_eq("mw_busy_jmp", 32'(out_vec), 32'(9'b1_1_0_1_0_1_0_1_0));
    tick("mw_busy_jmp");
    mem_ack = 1'b1;
    #1 check_eq("mw_ack_busy", 32'(out_vec), 32'(9'b1_1_0_1_0_0_1_0_0));
    tick("mw_ack_busy");
    idle();

    // Reset mid-wait: no error pulse afterwards.
    do_reset();
    mem_req = 1'b1;
    tick("rmw_req");
    mem_req = 1'b0;
    for (int i = 0; i < 5; i++) tick("rmw_wait");
    rst = 1'b1;
    #1 check_eq("rmw_out", 32'(out_vec), 0);
    tick("rmw_rst");
    rst = 1'b0;
    err_at = 0;
    for (int i = 0; i < int'(TO) + 4; i++) begin
      #1 if (bus_err || pc_stall) err_at++;
      tick("rmw_after");
    end
    check_eq("rmw_quiet", 32'(err_at), 0);
    check_eq("rmw_cnt", 32'(stall_cnt), 0);

    // Counter saturation.
    ex_busy = 1'b1;
    for (int i = 0; i < CntMax + 20; i++) tick("sat");
    check_eq("sat_cnt", 32'(stall_cnt), 32'(CntMax));
    idle();

    // Random traffic with alternating ack responsiveness.
    ack_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) ack_pct = ($urandom_range(0, 1) == 1) ? 50 : 4;
      rst      = ($urandom_range(0, 499) == 0);
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      ex_waddr = 5'($urandom_range(0, 3));
      rs1_re   = $urandom_range(0, 1) == 1;
      rs2_re   = $urandom_range(0, 1) == 1;
      ex_load  = $urandom_range(0, 2) == 0;
      ex_jump  = $urandom_range(0, 5) == 0;
      ex_busy  = $urandom_range(0, 7) == 0;
      mem_req  = $urandom_range(0, 3) == 0;
      mem_ack  = $urandom_range(0, 99) < ack_pct;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
